// File: rtl/ifid_queue.sv
// ifid_queue: in-order instruction queue between fetch and decode.
//
// Holds up to DEPTH {pc, instr} pairs. Fetch pushes through a valid/ready
// handshake, decode pops the oldest entry through a second valid/ready
// handshake. A flush empties the queue in one cycle for a control-flow
// redirect.
//
// Ports:
//   i_clk, i_rst     clock and synchronous active-high reset
//   i_flush          redirect; discards every queued entry
//   i_pre_valid      fetch offers {i_pc, i_instr}
//   o_pre_ready      queue can take an entry (registered state only)
//   o_post_valid     head entry valid for decode
//   i_post_ready     decode accepts the head entry
//   o_pc, o_instr    head entry (stale slot contents when o_post_valid=0)
//   o_count          current occupancy, 0..DEPTH
module ifid_queue #(
   parameter int CPU_WIDTH = 32,
   parameter int INS_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_pre_valid,
   output logic                       o_pre_ready,
   input  logic [CPU_WIDTH-1:0]       i_pc,
   input  logic [INS_WIDTH-1:0]       i_instr,
   output logic                       o_post_valid,
   input  logic                       i_post_ready,
   output logic [CPU_WIDTH-1:0]       o_pc,
   output logic [INS_WIDTH-1:0]       o_instr,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [CPU_WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [CPU_WIDTH-1:0] pc_mem_d    [DEPTH];
   logic [INS_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [INS_WIDTH-1:0] instr_mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q,  count_d;

   logic push;
   logic pop;

   // Readiness looks only at registered occupancy, so a full queue stays
   // not-ready even if decode pops in the same cycle.
   assign o_pre_ready  = (count_q != CW'(DEPTH)) && !i_rst;
   assign o_post_valid = (count_q != '0) && !i_rst;

   assign push = i_pre_valid  && o_pre_ready  && !i_flush;
   assign pop  = o_post_valid && i_post_ready && !i_flush;

   assign o_pc    = pc_mem_q[rd_ptr_q];
   assign o_instr = instr_mem_q[rd_ptr_q];
   assign o_count = count_q;

   always_comb begin
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (i_flush) begin
         // Storage is left alone; only the bookkeeping is cleared.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = i_pc;
            instr_mem_d[wr_ptr_q] = i_instr;
            wr_ptr_d              = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed bench for ifid_queue (DEPTH=4): a vector table of per-cycle
// inputs with expected post-edge outputs, then streaming and random-drain
// wrap-around sequences checked against a simple in-order model.
module tb_ifid_queue;

   logic        clk = 0;
   logic        rst, flush, pre_valid, post_ready;
   logic        pre_ready, post_valid;
   logic [31:0] pc, instr, o_pc, o_instr;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifid_queue #(.CPU_WIDTH(32), .INS_WIDTH(32), .DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
      .i_pc(pc), .i_instr(instr),
      .o_post_valid(post_valid), .i_post_ready(post_ready),
      .o_pc(o_pc), .o_instr(o_instr), .o_count(count)
   );

   typedef struct {
      logic        rst, flush, pv;
      logic [31:0] pc, instr;
      logic        prd;
      logic        e_pv, e_prdy;
      logic [2:0]  e_cnt;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   localparam int NV = 21;
   vec_t v [NV];

   function automatic vec_t mk(logic r, logic f, logic pv, logic [31:0] p, logic [31:0] ins,
                               logic prd, logic epv, logic eprdy, logic [2:0] ecnt,
                               logic [31:0] epc, logic [31:0] eins);
      vec_t t;
      t.rst = r; t.flush = f; t.pv = pv; t.pc = p; t.instr = ins; t.prd = prd;
      t.e_pv = epv; t.e_prdy = eprdy; t.e_cnt = ecnt; t.e_pc = epc; t.e_instr = eins;
      return t;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(logic r, logic f, logic pv, logic [31:0] p, logic [31:0] ins, logic prd);
      rst = r; flush = f; pre_valid = pv; pc = p; instr = ins; post_ready = prd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      //            rst f pv pc           instr     prd  pv prdy cnt pc           instr
      v[0]  = mk(1, 0, 0, 32'h0,        32'h0,    0,   0, 0, 0, 32'h0,        32'h0);
      v[1]  = mk(1, 0, 0, 32'h0,        32'h0,    0,   0, 0, 0, 32'h0,        32'h0);
      v[2]  = mk(0, 0, 1, 32'h80000000, 32'h413,  0,   1, 1, 1, 32'h80000000, 32'h413);
      v[3]  = mk(0, 0, 0, 32'h0,        32'h0,    1,   0, 1, 0, 32'h0,        32'h0);
      v[4]  = mk(0, 0, 1, 32'h80000000, 32'h11,   0,   1, 1, 1, 32'h80000000, 32'h11);
      v[5]  = mk(0, 0, 1, 32'h80000004, 32'h22,   0,   1, 1, 2, 32'h80000000, 32'h11);
      v[6]  = mk(0, 0, 1, 32'h80000008, 32'h33,   0,   1, 1, 3, 32'h80000000, 32'h11);
      v[7]  = mk(0, 0, 1, 32'h8000000C, 32'h44,   0,   1, 0, 4, 32'h80000000, 32'h11);
      v[8]  = mk(0, 0, 1, 32'h80000010, 32'h55,   0,   1, 0, 4, 32'h80000000, 32'h11);
      // full + pop: the offer is still refused, slot comes back next cycle
      v[9]  = mk(0, 0, 1, 32'h80000010, 32'h55,   1,   1, 1, 3, 32'h80000004, 32'h22);
      v[10] = mk(0, 0, 1, 32'h80000010, 32'h55,   0,   1, 0, 4, 32'h80000004, 32'h22);
      v[11] = mk(0, 0, 0, 32'h0,        32'h0,    1,   1, 1, 3, 32'h80000008, 32'h33);
      // flush with a push and pop offered: head shows stale slot 0, not the dropped pc
      v[12] = mk(0, 1, 1, 32'h80000100, 32'hAA,   1,   0, 1, 0, 32'h8000000C, 32'h44);
      v[13] = mk(0, 0, 1, 32'h80000200, 32'h66,   0,   1, 1, 1, 32'h80000200, 32'h66);
      v[14] = mk(0, 0, 1, 32'h80000204, 32'h77,   0,   1, 1, 2, 32'h80000200, 32'h66);
      v[15] = mk(1, 0, 1, 32'h80000300, 32'hBB,   1,   0, 0, 0, 32'h0,        32'h0);
      v[16] = mk(0, 0, 1, 32'h80000400, 32'h88,   0,   1, 1, 1, 32'h80000400, 32'h88);
      v[17] = mk(0, 0, 0, 32'h0,        32'h0,    1,   0, 1, 0, 32'h0,        32'h0);
      v[18] = mk(0, 0, 1, 32'h80000500, 32'h99,   0,   1, 1, 1, 32'h80000500, 32'h99);
      // reset and flush together: storage cleared as by reset
      v[19] = mk(1, 1, 0, 32'h0,        32'h0,    0,   0, 0, 0, 32'h0,        32'h0);
      v[20] = mk(0, 0, 0, 32'h0,        32'h0,    0,   0, 1, 0, 32'h0,        32'h0);

      #2;
      for (int i = 0; i < NV; i++) begin
         drive(v[i].rst, v[i].flush, v[i].pv, v[i].pc, v[i].instr, v[i].prd);
         tick();
         chk("post_valid", i, 32'(post_valid), 32'(v[i].e_pv));
         chk("pre_ready",  i, 32'(pre_ready),  32'(v[i].e_prdy));
         chk("count",      i, 32'(count),      32'(v[i].e_cnt));
         chk("pc",         i, o_pc,            v[i].e_pc);
         chk("instr",      i, o_instr,         v[i].e_instr);
      end

      // Streaming: continuous push and pop, count settles at 1.
      drive(1, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 1, 32'h80001000 + 32'(4 * i), 32'h1000 + 32'(i), 1);
         #1;
         if (i > 0) begin
            chk("stream_valid", i, 32'(post_valid), 32'd1);
            chk("stream_pc",    i, o_pc,    32'h80001000 + 32'(4 * (i - 1)));
            chk("stream_instr", i, o_instr, 32'h1000 + 32'(i - 1));
         end
         tick();
         chk("stream_count", i, 32'(count), 32'd1);
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk("stream_drain", 0, 32'(count), 32'd0);

      // Wrap-around: 10 entries, random decode readiness, in-order model.
      begin
         int pushed = 0, popped = 0, cyc = 0, occ = 0;
         drive(1, 0, 0, 0, 0, 0);
         tick();
         while (popped < 10 && cyc < 200) begin
            drive(0, 0, pushed < 10, 32'h80000000 + 32'(4 * pushed),
                  32'h2000 + 32'(pushed), 1'($urandom_range(0, 1)));
            #1;
            if (post_valid && post_ready) begin
               chk("wrap_pc",    popped, o_pc,    32'h80000000 + 32'(4 * popped));
               chk("wrap_instr", popped, o_instr, 32'h2000 + 32'(popped));
               popped++;
               occ--;
            end
            if (pre_valid && pre_ready) begin
               pushed++;
               occ++;
            end
            tick();
            chk("wrap_count", cyc, 32'(count), 32'(occ));
            cyc++;
         end
         chk("wrap_popped", 0, 32'(popped), 32'd10);
         chk("wrap_pushed", 0, 32'(pushed), 32'd10);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("final_empty", 0, 32'(post_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
